fpumac_col_sched: RTL and testbench

- Column scheduler/controller for the FPUMAC 3x3 convolution datapath.
- Accepts a strip of image columns over a valid/ready stream and latches the 3x3 filter at job start.
- Keeps a sliding three-column window registered on FPUMAC's col0/col1/col2 inputs and tracks FPUMAC's one-cycle result latency.
- Returns each result row to the downstream writer with valid/ready backpressure and marks the last result of the strip.

---
 rtl/fpumac_col_sched.sv | 162 ++++++++++++++++
 tb/tb_fpumac_col_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpumac_col_sched.sv
// fpumac_col_sched
//   Column scheduler for the FPUMAC 3x3 convolution datapath. A job is
//   started with a config handshake that latches the filter and the strip
//   length. Columns then arrive on a valid/ready stream and are shifted into
//   a three-column window that feeds FPUMAC directly. FPUMAC registers the
//   window one edge later, and its result is returned downstream with
//   valid/ready backpressure and a last-result marker.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active HIGH despite the name
//   cfg_valid/cfg_ready/cfg_cols/cfg_filter   job start (cfg_cols >= 3)
//   in_valid/in_ready/in_col                  column stream, 8 bits per pixel
//   mac_col0..2    window to FPUMAC, col0 is the oldest column
//   mac_filter     latched filter, tap k at [8k+7:8k]
//   mac_result     FPUMAC result pixels
//   out_valid/out_ready/out_pixels/out_last   result stream
//   done           one-cycle pulse after the final result handshake
//
// state | meaning
// IDLE  | waiting for a legal config request
// FILL  | loading the first two columns of the window
// RUN   | one result per accepted column, waits for downstream acceptance
// DONE  | pulses done, then returns to IDLE
module fpumac_col_sched #(
    parameter int COL_WIDTH = 10,
    parameter int MAX_COLS  = 1024,
    parameter int CW        = $clog2(MAX_COLS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CW-1:0]              cfg_cols,
    input  logic [71:0]                cfg_filter,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COL_WIDTH*8-1:0]     in_col,
    output logic [COL_WIDTH*8-1:0]     mac_col0,
    output logic [COL_WIDTH*8-1:0]     mac_col1,
    output logic [COL_WIDTH*8-1:0]     mac_col2,
    output logic [71:0]                mac_filter,
    input  logic [(COL_WIDTH-2)*8-1:0] mac_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(COL_WIDTH-2)*8-1:0] out_pixels,
    output logic                       out_last,
    output logic                       done
);

    localparam int PW = COL_WIDTH * 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] col0_q, col1_q, col2_q;
    logic [71:0]   filter_q;
    logic [CW-1:0] total_q, accepted_q, issued_q;
    logic          issue_pend_q, out_valid_q, done_q;

    logic in_ready_d, col_acc, out_hs, last_d;

    always_comb begin
        in_ready_d = 1'b0;
        case (state_q)
            S_FILL:  in_ready_d = 1'b1;
            // A new column is taken only when the window is free to move:
            // no result in flight and no unacknowledged result on the output.
            S_RUN:   in_ready_d = !issue_pend_q && (!out_valid_q || out_ready)
                                  && (accepted_q < total_q);
            default: in_ready_d = 1'b0;
        endcase
    end

    assign col_acc = in_valid && in_ready_d;
    assign out_hs  = out_valid_q && out_ready;
    // issued_q counts results already raised on out_valid, so the current
    // one is the last when it equals total-2.
    assign last_d  = out_valid_q && (issued_q == total_q - CW'(2));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            col0_q       <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            filter_q     <= '0;
            total_q      <= '0;
            accepted_q   <= '0;
            issued_q     <= '0;
            issue_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (col_acc) begin
                col0_q     <= col1_q;
                col1_q     <= col2_q;
                col2_q     <= in_col;
                accepted_q <= accepted_q + CW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid && (cfg_cols >= CW'(3))) begin
                        filter_q     <= cfg_filter;
                        total_q      <= cfg_cols;
                        accepted_q   <= '0;
                        issued_q     <= '0;
                        issue_pend_q <= 1'b0;
                        out_valid_q  <= 1'b0;
                        state_q      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (col_acc && (accepted_q == CW'(1))) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        if (last_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    // FPUMAC captures the window on this edge, so its result
                    // is present on mac_result from here on.
                    if (issue_pend_q) begin
                        out_valid_q  <= 1'b1;
                        issue_pend_q <= 1'b0;
                        issued_q     <= issued_q + CW'(1);
                    end
                    if (col_acc) begin
                        issue_pend_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready  = (state_q == S_IDLE);
    assign in_ready   = in_ready_d;
    assign mac_col0   = col0_q;
    assign mac_col1   = col1_q;
    assign mac_col2   = col2_q;
    assign mac_filter = filter_q;
    assign out_valid  = out_valid_q;
    assign out_pixels = mac_result;
    assign out_last   = last_d;
    assign done       = done_q;

endmodule

// File: tb/tb_fpumac_col_sched.sv
// tb_fpumac_col_sched
//   Directed bench for fpumac_col_sched with a behavioural FPUMAC stand-in
//   (registers a clamped 3x3 MAC of the window one edge after it is shown).
//   Ports: none.
module tb_fpumac_col_sched;

    localparam int COL_WIDTH = 10;
    localparam int MAX_COLS  = 1024;
    localparam int CW        = $clog2(MAX_COLS + 1);
    localparam int PW        = COL_WIDTH * 8;
    localparam int RW        = (COL_WIDTH - 2) * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid, cfg_ready;
    logic [CW-1:0] cfg_cols;
    logic [71:0]   cfg_filter;
    logic          in_valid, in_ready;
    logic [PW-1:0] in_col;
    logic [PW-1:0] mac_col0, mac_col1, mac_col2;
    logic [71:0]   mac_filter;
    logic [RW-1:0] mac_result = '0;
    logic          out_valid, out_ready;
    logic [RW-1:0] out_pixels;
    logic          out_last, done;

    int total_n = 0;
    int bad_n   = 0;

    logic [PW-1:0] cols_q[$];
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fpumac_col_sched #(.COL_WIDTH(COL_WIDTH), .MAX_COLS(MAX_COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cols(cfg_cols), .cfg_filter(cfg_filter),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .mac_col0(mac_col0), .mac_col1(mac_col1), .mac_col2(mac_col2), .mac_filter(mac_filter),
        .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels),
        .out_last(out_last), .done(done)
    );

    function automatic logic [RW-1:0] mac3(input logic [PW-1:0] c0, input logic [PW-1:0] c1,
                                           input logic [PW-1:0] c2, input logic [71:0] f);
        logic [RW-1:0]      r;
        logic signed [7:0]  t;
        logic [7:0]         px;
        int                 s;
        r = '0;
        for (int p = 0; p < COL_WIDTH - 2; p++) begin
            s = 0;
            for (int i = 0; i < 3; i++) begin
                t = f[(3*i)*8 +: 8];   px = c0[(p+i)*8 +: 8]; s += int'(t) * int'(px);
                t = f[(3*i+1)*8 +: 8]; px = c1[(p+i)*8 +: 8]; s += int'(t) * int'(px);
                t = f[(3*i+2)*8 +: 8]; px = c2[(p+i)*8 +: 8]; s += int'(t) * int'(px);
            end
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            r[p*8 +: 8] = 8'(s);
        end
        return r;
    endfunction

    // FPUMAC stand-in: captures the window on every edge
    always @(posedge clk) mac_result <= mac3(mac_col0, mac_col1, mac_col2, mac_filter);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        if (obs !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ccol(input logic [7:0] v);
        return {COL_WIDTH{v}};
    endfunction

    function automatic logic [RW-1:0] cres(input logic [7:0] v);
        return {(COL_WIDTH-2){v}};
    endfunction

    function automatic logic [71:0] ctaps(input logic [7:0] v);
        return {9{v}};
    endfunction

    // mode 0: always ready, 1: hold out_ready low 5 cycles at first result, 2: random
    task automatic run_job(input int ncols, input logic [71:0] filt, input int mode);
        int            sent = 0, got = 0, cyc = 0, last_hs = -10, stall = 0;
        bit            seen_first = 0, hold = 0, done_due = 0, fin = 0;
        logic [RW-1:0] held = '0;
        @(negedge clk);
        chk("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        cfg_valid  = 1'b1;
        cfg_cols   = CW'(ncols);
        cfg_filter = filt;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready_busy", 64'(cfg_ready), 64'(0));
        while (!fin && cyc < ncols * 12 + 60) begin
            if (done_due) begin
                chk("done_pulse", 64'(done), 64'(1));
                fin = 1;
            end else begin
                chk("done_early", 64'(done), 64'(0));
                if (hold) chk("pix_stable", 64'(out_pixels), 64'(held));
                case (mode)
                    0: out_ready = 1'b1;
                    1: begin
                        if (out_valid && !seen_first) begin
                            seen_first = 1;
                            stall = 5;
                        end
                        if (stall > 0) begin
                            out_ready = 1'b0;
                            stall--;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    default: out_ready = ($urandom_range(0, 1) == 1);
                endcase
                in_valid = (sent < ncols) && (mode != 2 || $urandom_range(0, 9) < 7);
                in_col   = in_valid ? cols_q[sent] : '0;
                #1;
                if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'(0));
                if (out_valid) begin
                    if (got < exp_q.size()) chk($sformatf("pix%0d", got), 64'(out_pixels), 64'(exp_q[got]));
                    else chk("extra_result", 64'(got), 64'(exp_q.size()));
                    chk($sformatf("last%0d", got), 64'(out_last), 64'(got == ncols - 3));
                    if (out_ready) begin
                        chk("rate", 64'((cyc - last_hs) >= 2), 64'(1));
                        last_hs = cyc;
                        got++;
                        if (got == ncols - 2) done_due = 1;
                    end
                end
                hold = out_valid && !out_ready;
                held = out_pixels;
                if (in_valid && in_ready) sent++;
                @(negedge clk);
                cyc++;
            end
        end
        chk("job_finished", 64'(fin), 64'(1));
        chk("result_count", 64'(got), 64'(ncols - 2));
        chk("cols_sent", 64'(sent), 64'(ncols));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_once", 64'(done), 64'(0));
        chk("idle_again", 64'(cfg_ready), 64'(1));
        chk("filter_held", 64'(mac_filter[63:0]), 64'(filt[63:0]));
    endtask

    task automatic build_exp(input logic [71:0] filt);
        exp_q.delete();
        for (int k = 0; k + 2 < cols_q.size(); k++)
            exp_q.push_back(mac3(cols_q[k], cols_q[k+1], cols_q[k+2], filt));
    endtask

    logic [71:0] ident;

    initial begin
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_cols = '0; cfg_filter = '0;
        in_valid = 1'b0; in_col = '0; out_ready = 1'b0;
        ident = 72'h0000_0000_0100_0000_00;
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_filter", 64'(mac_filter[63:0]), 64'(0));
        rst_n = 1'b0;

        // identity filter, three columns -> one result equal to the middle column
        cols_q = '{ccol(8'd10), ccol(8'd20), ccol(8'd30)};
        exp_q  = '{cres(8'd20)};
        run_job(3, ident, 0);

        // saturation high then low
        cols_q = '{ccol(8'd255), ccol(8'd255), ccol(8'd255), ccol(8'd255), ccol(8'd255)};
        exp_q  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        run_job(5, ctaps(8'h01), 0);
        exp_q  = '{64'h0, 64'h0, 64'h0};
        run_job(5, ctaps(8'hFF), 0);

        // backpressure with ordered results
        cols_q = '{ccol(8'd10), ccol(8'd20), ccol(8'd30), ccol(8'd40), ccol(8'd50), ccol(8'd60)};
        exp_q  = '{cres(8'd20), cres(8'd30), cres(8'd40), cres(8'd50)};
        run_job(6, ident, 1);

        // illegal lengths are ignored
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_cols  = (k == 0) ? CW'(2) : CW'(0);
            cfg_filter = ident;
            in_valid  = 1'b1;
            in_col    = ccol(8'd7);
            out_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("illegal_cfg_ready", 64'(cfg_ready), 64'(1));
                chk("illegal_in_ready", 64'(in_ready), 64'(0));
                chk("illegal_out_valid", 64'(out_valid), 64'(0));
            end
            cfg_valid = 1'b0;
            in_valid  = 1'b0;
        end
        cols_q = '{ccol(8'd3), ccol(8'd5), ccol(8'd9)};
        exp_q  = '{cres(8'd5)};
        run_job(3, ident, 0);

        // reset after 4 of 8 columns
        cols_q.delete();
        for (int k = 0; k < 8; k++) cols_q.push_back(ccol(8'(k + 1)));
        @(negedge clk);
        cfg_valid = 1'b1; cfg_cols = CW'(8); cfg_filter = ident;
        @(negedge clk);
        cfg_valid = 1'b0;
        begin
            int sent = 0, cyc = 0;
            while (sent < 4 && cyc < 40) begin
                in_valid  = 1'b1;
                in_col    = cols_q[sent];
                out_ready = 1'b1;
                #1;
                if (in_ready) sent++;
                @(negedge clk);
                cyc++;
            end
            chk("mid_sent", 64'(sent), 64'(4));
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("mid_out_valid", 64'(out_valid), 64'(0));
        chk("mid_col0", 64'(mac_col0[63:0]), 64'(0));
        chk("mid_col1", 64'(mac_col1[63:0]), 64'(0));
        chk("mid_col2", 64'(mac_col2[63:0]), 64'(0));
        chk("mid_filter", 64'(mac_filter[63:0]), 64'(0));
        chk("mid_cfg_ready", 64'(cfg_ready), 64'(1));
        repeat (3) begin
            chk("mid_no_done", 64'(done), 64'(0));
            @(negedge clk);
        end
        cols_q = '{ccol(8'd40), ccol(8'd50), ccol(8'd60), ccol(8'd70)};
        exp_q  = '{cres(8'd50), cres(8'd60)};
        run_job(4, ident, 0);

        // random jobs against the software MAC model
        for (int j = 0; j < 40; j++) begin
            int          n;
            logic [71:0] f;
            logic [PW-1:0] c;
            n = $urandom_range(3, 32);
            for (int t = 0; t < 9; t++)
                f[t*8 +: 8] = (j % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8) - 4);
            cols_q.delete();
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < COL_WIDTH; b++) c[b*8 +: 8] = 8'($urandom_range(0, 255));
                cols_q.push_back(c);
            end
            build_exp(f);
            run_job(n, f, 2);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
